// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
//
// 8N1 serial receiver for the SoC UART RX pad. The line is sampled at mid-bit
// at a fixed divider (CLK_DIV clocks per bit). Each good byte is pushed into a
// small first-word-fall-through FIFO that the core-side register block drains.
// Framing errors and overruns are reported as one-cycle pulses.
//
// Parameters
//   CLK_DIV     system clocks per serial bit (>= 4)
//   FIFO_DEPTH  receive FIFO entries (power of two, >= 2)
//
// Ports
//   sys_clk_i     in   system clock (single clock domain)
//   rst_i         in   asynchronous active-high reset
//   rx_i          in   raw serial line from the pad, asynchronous, idles high
//   rd_en_i       in   pop the FIFO head (ignored while the FIFO is empty)
//   rd_data_o     out  FIFO head byte, meaningful while rd_valid_o = 1
//   rd_valid_o    out  FIFO not empty
//   fifo_count_o  out  number of occupied FIFO entries
//   frame_err_o   out  one-cycle pulse: stop bit sampled as 0, byte discarded
//   overrun_o     out  one-cycle pulse: good byte dropped, FIFO full
// -----------------------------------------------------------------------------
module uart_byte_rx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               sys_clk_i,
  input  logic                               rst_i,
  input  logic                               rx_i,
  input  logic                               rd_en_i,
  output logic [7:0]                         rd_data_o,
  output logic                               rd_valid_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o,
  output logic                               frame_err_o,
  output logic                               overrun_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  // The cycle counter counts down to zero, so a load of N-1 expires N cycles
  // after the load.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Input conditioning: two-flop synchronizer plus one history flop for
  // falling-edge detection. All reset to the idle line level.
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rx_sync;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_sync = sync2_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;

  logic             cnt_expired;
  logic             stop_ok;       // stop-sample cycle with a valid stop bit
  logic             stop_bad;      // stop-sample cycle with a low stop bit

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign cnt_expired = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Only a genuine high-to-low transition starts a frame; a line that
        // is held low never produces one.
        if (!rx_sync && prev_q) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end

      ST_START: begin
        if (cnt_expired) begin
          if (!rx_sync) begin
            state_d = ST_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_expired) begin
          // LSB arrives first, so shifting in at the MSB leaves bit 0 in
          // position 0 after the eighth sample.
          shift_d = {rx_sync, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_expired) begin
          // Returning to IDLE at mid-stop leaves half a bit of margin for
          // the next start edge, so frames with no idle gap are not lost.
          state_d = ST_IDLE;
          if (rx_sync) begin
            stop_ok = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO: circular buffer, write/read pointers and occupancy count.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_d;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_d;
  logic                        frame_err_q;
  logic                        overrun_q;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  logic                        overrun_d;
  logic [FIFO_DEPTH-1:0][7:0]  mem_rd;

  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);
  assign pop        = rd_en_i && !fifo_empty;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  // the byte in that case.
  assign push       = stop_ok && (!fifo_full || pop);
  assign overrun_d  = stop_ok && fifo_full && !rd_en_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    // Pointer width equals log2(depth), so the increment wraps on its own.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      frame_err_q <= stop_bad;
      overrun_q   <= overrun_d;
    end
  end

  // Storage entries are cleared on reset so the head reads 8'h00 afterwards.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [7:0] entry_q;
    logic       entry_we;

    assign entry_we = push && (wr_ptr_q == PTR_W'(gi));

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
        entry_q <= '0;
      end else if (entry_we) begin
        entry_q <= shift_q;
      end
    end

    assign mem_rd[gi] = entry_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_data_o    = mem_rd[rd_ptr_q];
  assign rd_valid_o   = !fifo_empty;
  assign fifo_count_o = occ_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;

  localparam int CLK_DIV   = 16;
  localparam int DEPTH     = 4;
  // Start drive (at a negedge) to first cycle the pushed byte is visible,
  // counted in rising edges: 2 sync edges + half bit + 9 bits + write edge.
  localparam int FRAME_LAT = CLK_DIV / 2 + 9 * CLK_DIV + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_byte_rx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk_i    (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .rd_en_i      (rd_en),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .fifo_count_o (fifo_count),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  logic [7:0]  exp_q[$];

  // Monitor: cycle counter and pulse/edge bookkeeping, sampled on negedge.
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  int unsigned fe_cyc = 0;
  int unsigned ov_cyc = 0;
  int unsigned vrise_cyc = 0;
  logic        valid_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_valid && !valid_d) vrise_cyc = cyc;
    valid_d = rd_valid;
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (overrun)   begin ov_cnt++; ov_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Must be called at a negedge; returns at a negedge after ten full bits.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit expect_store);
    logic [9:0] frame;
    frame     = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    if (expect_store) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CLK_DIV) @(negedge clk);
    end
  endtask

  // Compare the head against the scoreboard, then pop it.
  task automatic read_check(input string tag);
    logic [7:0] exp;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, rd_data, exp);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int exp_fe;
    int exp_ov;
    exp_fe = 0;
    exp_ov = 0;
    rst    = 1'b1;
    rx     = 1'b1;
    rd_en  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_data", rd_data, 8'h00);
    check("rst_fe", frame_err, 0);
    check("rst_ov", overrun, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with latency check
    send_byte(8'hA5, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("single_latency", vrise_cyc - start_cyc, FRAME_LAT);
    check("single_count", fifo_count, 1);
    read_check("single");
    check("single_empty_valid", rd_valid, 0);
    check("single_empty_count", fifo_count, 0);
    check("single_fe", fe_cnt, exp_fe);
    check("single_ov", ov_cnt, exp_ov);

    // Back-to-back frames, no idle gap
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("b2b_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) read_check("b2b");
    check("b2b_count_after", fifo_count, 0);
    check("b2b_fe", fe_cnt, exp_fe);
    check("b2b_ov", ov_cnt, exp_ov);

    // Glitch rejection, then a normal byte
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", fifo_count, 0);
    check("glitch_fe", fe_cnt, exp_fe);
    check("glitch_ov", ov_cnt, exp_ov);
    send_byte(8'h5A, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    read_check("post_glitch");

    // Framing error, then recovery
    send_byte(8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    exp_fe++;
    repeat (20) @(negedge clk);
    check("ferr_pulses", fe_cnt, exp_fe);
    check("ferr_timing", fe_cyc - start_cyc, FRAME_LAT);
    check("ferr_count", fifo_count, 0);
    check("ferr_ov", ov_cnt, exp_ov);
    send_byte(8'h55, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    read_check("post_ferr");
    check("post_ferr_fe", fe_cnt, exp_fe);

    // Overrun: fifth byte dropped
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b1);
    send_byte(8'h14, 1'b1, 1'b0);
    exp_ov++;
    repeat (2) @(negedge clk);
    check("ovr_pulses", ov_cnt, exp_ov);
    check("ovr_timing", ov_cyc - start_cyc, FRAME_LAT);
    check("ovr_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) read_check("ovr");
    check("ovr_fe", fe_cnt, exp_fe);

    // Push and pop in the same cycle while full: no overrun
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b1);
    fork
      send_byte(8'h14, 1'b1, 1'b1);
      begin
        repeat (FRAME_LAT - 1) @(posedge clk);
        @(negedge clk);
        read_check("simul_pop");
      end
    join
    repeat (2) @(negedge clk);
    check("simul_ov", ov_cnt, exp_ov);
    check("simul_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) read_check("simul");
    check("simul_count_after", fifo_count, 0);

    // Reset during data bit 4 with two bytes queued
    send_byte(8'h21, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    check("mid_pre_count", fifo_count, 2);
    fork
      send_byte(8'hF0, 1'b1, 1'b0);
      begin
        repeat (5 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_data", rd_data, 8'h00);
        check("mid_rst_fe", frame_err, 0);
        check("mid_rst_ov", overrun, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("post_rst_count0", fifo_count, 0);
    send_byte(8'h81, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("post_rst_count", fifo_count, 1);
    read_check("post_rst");
    check("post_rst_empty", fifo_count, 0);
    check("final_fe", fe_cnt, exp_fe);
    check("final_ov", ov_cnt, exp_ov);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
